itrx_aib_phy_rst_seq: RTL and testbench
=======================================

ITRX_AIB_PHY_RST_SEQ -- requirements
Module: itrx_aib_phy_rst_seq

Interface
REQ-001 The block SHALL have parameter NDFFS, default 2, meaning synchronizer depth (legal 2..4).
REQ-002 The block SHALL have parameter NCH, default 4, meaning number of sequenced reset outputs (legal 1..8).
REQ-003 The block SHALL have parameter CNTW, default 8, meaning width of the gap counter (legal 2..16).
REQ-004 The block SHALL have port clk  input  1  clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port scan_mode  input  1  DFT bypass select; 1 means rst_out_n follows rst_n combinationally.
REQ-007 The block SHALL have port sw_rst_req  input  1  synchronous software reset request, level.
REQ-008 The block SHALL have port gap_cnt  input  CNTW  quasi-static inter-channel gap; each gap lasts gap_cnt+1 cycles.
REQ-009 The block SHALL have port rst_out_n  output  NCH  sequenced resets, active-low; bit 0 releases first.
REQ-010 The block SHALL have port sw_rst_ack  output  1  software reset hold complete.
REQ-011 The block SHALL have port seq_done  output  1  all channels released.

Function
REQ-012 The block SHALL synchronize rst_n through an NDFFS-deep chain: async clear to 0, constant 1 shifted in; chain output rises at the NDFFS-th clk edge after rst_n rises.
REQ-013 The block SHALL use FSM states WAIT_SYNC, GAP, DONE, SW_HOLD, SW_ACK.
REQ-014 WAIT_SYNC: all rst_out_n=0; SHALL go to GAP with channel index 0 and gap counter loaded from gap_cnt when the sync output is 1.
REQ-015 GAP: counter decrements each cycle; at count 0 the block SHALL release rst_out_n[index], increment index, reload counter from gap_cnt; after release of index NCH-1, go to DONE.
REQ-016 Release timing SHALL be: channel k deasserts at clk edge NDFFS + (k+1)*(gap_cnt+1) after rst_n rises (gap_cnt constant).
REQ-017 seq_done SHALL assert at the edge after channel NCH-1 releases and remain 1 only while in DONE.
REQ-018 Released channels SHALL stay released (no glitches) until an assertion event (rst_n low, software reset).
REQ-019 gap_cnt SHALL be sampled only at counter load; changes mid-gap take effect at the next gap.
REQ-020 DONE with sw_rst_req sampled 1 at edge E: all rst_out_n=0 and seq_done=0 at E; go to SW_HOLD with counter loaded from gap_cnt.
REQ-021 SW_HOLD: after gap_cnt+1 cycles, sw_rst_ack SHALL assert (edge E+gap_cnt+1); go to SW_ACK.
REQ-022 SW_ACK: while sw_rst_req=1, hold; at edge F where sw_rst_req sampled 0, sw_rst_ack=0 and GAP starts at index 0; channel k releases at F+(k+1)*(gap_cnt+1).
REQ-023 sw_rst_req SHALL be ignored in WAIT_SYNC and GAP; a drop of sw_rst_req during SW_HOLD SHALL NOT shorten the hold (ack still pulses one cycle).
REQ-024 gap_cnt=0 SHALL release one channel per cycle; gap_cnt=all-ones SHALL not overflow (counter width CNTW).
REQ-025 scan_mode=1 SHALL force every rst_out_n bit equal to rst_n combinationally; seq_done and sw_rst_ack unaffected.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear sync chain, FSM (WAIT_SYNC), counter, index, rst_out_n=0, sw_rst_ack=0, seq_done=0, at any point including mid-sequence or mid-software-reset.
REQ-027 No output SHALL deassert except synchronously to clk.

Verification
REQ-028 NDFFS=2, NCH=4, gap_cnt=3, rst_n rises -> rst_out_n bits release at edges 6, 10, 14, 18; seq_done=1 at edge 19.
REQ-029 gap_cnt=0, NCH=4 -> releases at edges 3, 4, 5, 6; seq_done at 7.
REQ-030 DONE, gap_cnt=3, sw_rst_req high at edge E for 10 cycles -> rst_out_n=4'b0000 at E, sw_rst_ack=1 at E+4; req low at F -> ack=0 at F, releases at F+4, F+8, F+12, F+16.
REQ-031 rst_n low for 1 ns between edges 11 and 12 of REQ-028 sequence -> rst_out_n=0 immediately, seq_done stays 0, restart with releases at 6/10/14/18 edges after new rising rst_n.
REQ-032 scan_mode=1, toggle rst_n 0/1 with clk stopped -> rst_out_n equals {NCH{rst_n}} each time.
REQ-033 sw_rst_req pulsed 1 cycle during GAP -> ignored, sequence timing unchanged, sw_rst_ack stays 0.

Source files
------------

// File: rtl/itrx_aib_phy_rst_seq.sv
// AIB PHY reset sequencer.
// Synchronizes the asynchronous rst_n, then releases NCH active-low channel
// resets one at a time, spaced by (gap_cnt + 1) clock cycles, lowest channel
// first. Once every channel is out of reset, a level software request
// re-asserts all channels, holds them for (gap_cnt + 1) cycles, acknowledges,
// and replays the release sequence when the request is withdrawn.
// scan_mode bypasses the sequencer so rst_n drives every channel directly.

module itrx_aib_phy_rst_seq #(
    parameter int unsigned NDFFS = 2,  // synchronizer depth, 2..4
    parameter int unsigned NCH   = 4,  // number of sequenced channels, 1..8
    parameter int unsigned CNTW  = 8   // gap counter width, 2..16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_mode,
    input  logic            sw_rst_req,
    input  logic [CNTW-1:0] gap_cnt,
    output logic [NCH-1:0]  rst_out_n,
    output logic            sw_rst_ack,
    output logic            seq_done
);

    localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

    typedef enum logic [2:0] {
        StWaitSync,
        StGap,
        StDone,
        StSwHold,
        StSwAck
    } state_e;

    state_e            state_q, state_d;
    logic [NDFFS-1:0]  sync_q;
    logic              sync_out;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NCH-1:0]    rst_q, rst_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic              gap_step;

    // Reset synchronizer: asynchronous assertion, release after NDFFS edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NDFFS-2:0], 1'b1};
        end
    end

    assign sync_out = sync_q[NDFFS-1];

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitSync;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic for the release sequence and software reset handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        gap_step = 1'b0;

        unique case (state_q)
            StWaitSync: begin
                rst_d = '0;
                idx_d = '0;
                // The counter tracks gap_cnt while waiting, so the edge that
                // first sees the synchronized reset already counts as the
                // first cycle of the first gap.
                cnt_d = gap_cnt;
                if (sync_out) begin
                    state_d  = StGap;
                    gap_step = 1'b1;
                end
            end
            StGap: begin
                gap_step = 1'b1;
            end
            StDone: begin
                if (sw_rst_req) begin
                    rst_d   = '0;
                    cnt_d   = gap_cnt;
                    state_d = StSwHold;
                end else begin
                    done_d = 1'b1;
                end
            end
            StSwHold: begin
                // Request is ignored here: the hold always runs to completion.
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = StSwAck;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            StSwAck: begin
                if (sw_rst_req) begin
                    ack_d = 1'b1;
                end else begin
                    idx_d   = '0;
                    cnt_d   = gap_cnt;
                    state_d = StGap;
                end
            end
            default: begin
                rst_d   = '0;
                state_d = StWaitSync;
            end
        endcase

        // One gap cycle: release the current channel when the count expires.
        if (gap_step) begin
            if (cnt_q == '0) begin
                rst_d[idx_q] = 1'b1;
                cnt_d        = gap_cnt;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end else begin
                cnt_d = cnt_q - CNTW'(1);
            end
        end
    end

    // DFT bypass: channel resets follow rst_n directly in scan mode.
    assign rst_out_n  = scan_mode ? {NCH{rst_n}} : rst_q;
    assign sw_rst_ack = ack_q;
    assign seq_done   = done_q;

endmodule

// File: tb/tb_itrx_aib_phy_rst_seq.sv
// Randomized scoreboard bench for itrx_aib_phy_rst_seq.
// The reference model works in absolute edge numbers: channel k of a
// sequence starting at base b releases at b + (k+1)*(g+1).

module tb_itrx_aib_phy_rst_seq;

    localparam int unsigned NDFFS = 2;
    localparam int unsigned NCH   = 4;
    localparam int unsigned CNTW  = 8;

    typedef struct packed {
        logic [NCH-1:0] r;
        logic           a;
        logic           d;
    } exp_t;

    logic            clk;
    logic            clk_en;
    logic            rst_n;
    logic            scan_mode;
    logic            sw_rst_req;
    logic [CNTW-1:0] gap_cnt;
    logic [NCH-1:0]  rst_out_n;
    logic            sw_rst_ack;
    logic            seq_done;

    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    // Model state: mode 0 = sequence/done, 1 = software hold, 2 = ack.
    int m_t;
    int m_mode;
    int m_base;
    int m_e;
    int g;

    itrx_aib_phy_rst_seq #(
        .NDFFS (NDFFS),
        .NCH   (NCH),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_mode  (scan_mode),
        .sw_rst_req (sw_rst_req),
        .gap_cnt    (gap_cnt),
        .rst_out_n  (rst_out_n),
        .sw_rst_ack (sw_rst_ack),
        .seq_done   (seq_done)
    );

    // Gateable clock, always stopped while low.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_mode = 0;
        m_base = NDFFS;
        m_e    = 0;
    endtask

    // Advance the model by one clock edge with req as sampled at that edge.
    function automatic exp_t model_edge(input logic req);
        exp_t e;
        int   lastrel;
        m_t++;
        lastrel = m_base + NCH * (g + 1);
        case (m_mode)
            0: if (m_t > lastrel && req) begin
                m_mode = 1;
                m_e    = m_t;
            end
            1: if (m_t >= m_e + g + 1) m_mode = 2;
            default: if (!req) begin
                m_mode = 0;
                m_base = m_t;
            end
        endcase
        lastrel = m_base + NCH * (g + 1);
        e = '0;
        if (m_mode == 0) begin
            for (int k = 0; k < NCH; k++) e.r[k] = (m_t >= m_base + (k + 1) * (g + 1));
            e.d = (m_t > lastrel);
        end else if (m_mode == 2) begin
            e.a = 1'b1;
        end
        return e;
    endfunction

    // Monitor: compare each expected vector half a cycle after its edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rst_out_n", 32'(rst_out_n), 32'(e.r));
            chk("sw_rst_ack", 32'(sw_rst_ack), 32'(e.a));
            chk("seq_done", 32'(seq_done), 32'(e.d));
        end
    end

    task automatic check_all_low(input string nm);
        chk({nm, "_rst_out_n"}, 32'(rst_out_n), 32'd0);
        chk({nm, "_ack"}, 32'(sw_rst_ack), 32'd0);
        chk({nm, "_done"}, 32'(seq_done), 32'd0);
    endtask

    // One reset-release run of the given length, optional async reset pulse
    // after edge rst_at, optional random software requests.
    task automatic do_run(input int ncyc, input int rst_at, input bit req_en);
        int req_len;
        req_len    = 0;
        sw_rst_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            sb_q.push_back(model_edge(sw_rst_req));
            #2;
            if (req_en) begin
                if (sw_rst_req) begin
                    if (req_len == 0) sw_rst_req = 1'b0;
                    else req_len--;
                end else if ($urandom_range(0, 15) == 0) begin
                    sw_rst_req = 1'b1;
                    req_len    = $urandom_range(0, 12);
                end
            end
            if (i == rst_at) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1 check_all_low("mid_reset");
                #1 rst_n = 1'b1;
                model_reset();
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        sw_rst_req = 1'b0;
        #1 check_all_low("end_reset");
    endtask

    initial begin
        int g_tab[10];
        int rst_at;
        int ncyc;
        g_tab       = '{3, 3, 0, 255, 1, 2, 5, 0, 7, 4};
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        clk_en      = 1'b1;
        rst_n       = 1'b0;
        scan_mode   = 1'b0;
        sw_rst_req  = 1'b0;
        gap_cnt     = '0;
        g           = 0;
        model_reset();
        #1 check_all_low("reset_state");

        for (int run = 0; run < 10; run++) begin
            g       = g_tab[run];
            gap_cnt = CNTW'(g);
            rst_at  = -1;
            if (run == 1) rst_at = 10;  // pulse between edges 11 and 12
            else if (run >= 5 && $urandom_range(0, 1) == 1)
                rst_at = $urandom_range(0, NDFFS + NCH * (g + 1) + 4);
            ncyc = 3 * (NCH + 2) * (g + 1) + 60;
            if (g > 100) ncyc = NDFFS + NCH * (g + 1) + 300;
            do_run(ncyc, rst_at, run != 0 && run != 2);
        end

        // Scan bypass with the clock stopped low.
        @(negedge clk);
        clk_en    = 1'b0;
        scan_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3 rst_n = 1'b1;
            #1 chk("scan_high", 32'(rst_out_n), 32'({NCH{1'b1}}));
            chk("scan_done", 32'(seq_done), 32'd0);
            #3 rst_n = 1'b0;
            #1 chk("scan_low", 32'(rst_out_n), 32'd0);
        end
        scan_mode = 1'b0;
        #1 chk("scan_off", 32'(rst_out_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
